// File: rtl/rom_loader.sv
// rom_loader: receives a length-prefixed, checksummed byte image and
// writes it into the program ROM store, holding the CPU until it is valid.
module rom_loader (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  inData,
  input  logic        inValid,
  output logic        inReady,
  output logic        romWe,
  output logic [11:0] romWaddr,
  output logic [7:0]  romWdata,
  output logic        cpuHold,
  output logic        loadDone,
  output logic        loadErr
);

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  lenhi_q, lenhi_d;
  logic [12:0] rem_q, rem_d;
  logic [11:0] cnt_q, cnt_d;
  logic [7:0]  csum_q, csum_d;
  logic        we_q, we_d;
  logic [11:0] waddr_q, waddr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        hold_q, hold_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        acc;
  logic [11:0] len_w;

  // A pending ROM write blocks intake for exactly one cycle.
  assign inReady  = !we_q;
  assign acc      = inValid && inReady;
  assign len_w    = {lenhi_q, inData};
  assign romWe    = we_q;
  assign romWaddr = waddr_q;
  assign romWdata = wdata_q;
  assign cpuHold  = hold_q;
  assign loadDone = done_q;
  assign loadErr  = err_q;

  // Next-state, datapath and status decisions.
  always_comb begin
    state_d = state_q;
    lenhi_d = lenhi_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    csum_d  = csum_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    hold_d  = hold_q;
    done_d  = done_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (acc && inData == SYNC_BYTE)
          state_d = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (acc) begin
          lenhi_d = inData[3:0];
          state_d = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (acc) begin
          // A zero length field means a full 4096-byte image.
          rem_d   = (len_w == 12'd0) ? 13'd4096
                                     : {1'b0, len_w};
          cnt_d   = 12'd0;
          csum_d  = 8'd0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (we_q) begin
          if (rem_q == 13'd0)
            state_d = S_CSUM;
        end else if (acc) begin
          we_d    = 1'b1;
          waddr_d = cnt_q;
          wdata_d = inData;
          cnt_d   = cnt_q + 12'd1;
          csum_d  = csum_q + inData;
          rem_d   = rem_q - 13'd1;
        end
      end
      S_CSUM: begin
        if (acc) begin
          if (inData == csum_q) begin
            state_d = S_DONE;
            hold_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
      S_DONE, S_ERR: begin
        if (acc && inData == SYNC_BYTE) begin
          state_d = S_LEN_HI;
          hold_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset drops any pending write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      lenhi_q <= 4'd0;
      rem_q   <= 13'd0;
      cnt_q   <= 12'd0;
      csum_q  <= 8'd0;
      we_q    <= 1'b0;
      waddr_q <= 12'd0;
      wdata_q <= 8'd0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lenhi_q <= lenhi_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      csum_q  <= csum_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: directed image loads checked against an expected-write
// queue built from each image, plus per-cycle handshake invariants.
module tb_rom_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  inData;
  logic        inValid;
  logic        inReady;
  logic        romWe;
  logic [11:0] romWaddr;
  logic [7:0]  romWdata;
  logic        cpuHold;
  logic        loadDone;
  logic        loadErr;

  rom_loader dut (
    .clk      (clk),
    .rst      (rst),
    .inData   (inData),
    .inValid  (inValid),
    .inReady  (inReady),
    .romWe    (romWe),
    .romWaddr (romWaddr),
    .romWdata (romWdata),
    .cpuHold  (cpuHold),
    .loadDone (loadDone),
    .loadErr  (loadErr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t  expq[$];
  int   checks = 0;
  int   fails  = 0;
  bit   gap    = 1'b1;
  int   cyc    = 0;
  int   t0, t1;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Per-cycle compare against the expected-write queue.
  logic [11:0] pa;
  logic [7:0]  pd;
  logic        prst = 1'b1;
  wr_t         e;
  always @(negedge clk) begin
    if (!rst && !prst) begin
      chk("inReady_vs_romWe", {31'd0, inReady}, {31'd0, !romWe});
      if (romWe) begin
        if (expq.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected none",
                   romWaddr, romWdata);
        end else begin
          e = expq.pop_front();
          chk("waddr", {20'd0, romWaddr}, {20'd0, e.a});
          chk("wdata", {24'd0, romWdata}, {24'd0, e.d});
        end
      end else begin
        chk("waddr_hold", {20'd0, romWaddr}, {20'd0, pa});
        chk("wdata_hold", {24'd0, romWdata}, {24'd0, pd});
      end
    end
    pa   = romWaddr;
    pd   = romWdata;
    prst = rst;
  end

  function automatic logic [7:0] sum8(input logic [7:0] q[$]);
    logic [7:0] s = 8'd0;
    foreach (q[i]) s = s + q[i];
    return s;
  endfunction

  task automatic send(input logic [7:0] b);
    int n = 0;
    inData  = b;
    inValid = 1'b1;
    while (!inReady && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!inReady) begin
      checks++;
      fails++;
      $display("FAIL accept_timeout: got inReady 0 expected 1 (byte %0h)", b);
    end
    @(posedge clk);
    #1;
    if (gap) begin
      inValid = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  // Header plus data; expected writes are queued from the image itself.
  task automatic load(input logic [3:0] hin,
                      input logic [7:0] data[$]);
    int          l  = data.size();
    logic [11:0] ln = l[11:0];
    foreach (data[i])
      expq.push_back('{a: i[11:0], d: data[i]});
    send(8'hA5);
    send({hin, ln[11:8]});
    send(ln[7:0]);
    foreach (data[i]) begin
      send(data[i]);
      if (i == 0) t0 = cyc;
    end
    t1 = cyc;
  endtask

  logic [7:0] img[$];
  logic [7:0] big[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    inValid = 1'b0;
    inData  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_inReady",  {31'd0, inReady},  32'd1);
    chk("rst_romWe",    {31'd0, romWe},    32'd0);
    chk("rst_waddr",    {20'd0, romWaddr}, 32'd0);
    chk("rst_wdata",    {24'd0, romWdata}, 32'd0);
    chk("rst_cpuHold",  {31'd0, cpuHold},  32'd1);
    chk("rst_loadDone", {31'd0, loadDone}, 32'd0);
    chk("rst_loadErr",  {31'd0, loadErr},  32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic three-byte image.
    img = '{8'h12, 8'h34, 8'h56};
    chk("pin_csum_3", {24'd0, sum8(img)}, 32'h9C);
    load(4'h0, img);
    chk("hold_before_csum", {31'd0, cpuHold}, 32'd1);
    gap = 1'b0;
    send(8'h9C);
    gap = 1'b1;
    chk("hold_after_csum", {31'd0, cpuHold},  32'd0);
    chk("done_ok",         {31'd0, loadDone}, 32'd1);
    chk("err_ok",          {31'd0, loadErr},  32'd0);
    chk("writes_3",        expq.size(),       32'd0);

    // Same image, wrong checksum; upper length nibble is junk.
    load(4'hF, img);
    send(8'h9D);
    chk("err_bad",   {31'd0, loadErr},  32'd1);
    chk("hold_bad",  {31'd0, cpuHold},  32'd1);
    chk("done_bad",  {31'd0, loadDone}, 32'd0);
    chk("writes_3b", expq.size(),       32'd0);

    // Noise is discarded in ERR, then a one-byte image.
    send(8'h00);
    send(8'hFF);
    chk("err_noise", {31'd0, loadErr}, 32'd1);
    img = '{8'h7E};
    load(4'h0, img);
    chk("err_cleared", {31'd0, loadErr}, 32'd0);
    send(8'h7E);
    chk("done_1",   {31'd0, loadDone}, 32'd1);
    chk("hold_1",   {31'd0, cpuHold},  32'd0);
    chk("writes_1", expq.size(),       32'd0);

    // Full 4096-byte image with inValid held high throughout.
    big = {};
    for (int i = 0; i < 4096; i++) big.push_back(8'h01);
    chk("pin_csum_4096", {24'd0, sum8(big)}, 32'h00);
    gap = 1'b0;
    load(4'h0, big);
    chk("stream_rate", t1 - t0, 32'd8190);
    send(8'h00);
    gap = 1'b1;
    chk("done_4096",   {31'd0, loadDone}, 32'd1);
    chk("writes_4096", expq.size(),       32'd0);
    repeat (3) @(posedge clk);
    #1;

    // Reset after two of three data bytes.
    expq.push_back('{a: 12'd0, d: 8'h11});
    expq.push_back('{a: 12'd1, d: 8'h22});
    send(8'hA5);
    send(8'h00);
    send(8'h03);
    inValid = 1'b1;
    inData  = 8'h11;
    @(posedge clk); #1;
    inValid = 1'b0;
    @(posedge clk); #1;
    inValid = 1'b1;
    inData  = 8'h22;
    @(posedge clk); #1;
    inValid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("writes_partial", expq.size(), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_hold", {31'd0, cpuHold},  32'd1);
    chk("abort_we",   {31'd0, romWe},    32'd0);
    chk("abort_done", {31'd0, loadDone}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    send(8'h33);
    repeat (3) @(posedge clk);
    #1;
    img = '{8'hAA, 8'hBB};
    chk("pin_csum_2", {24'd0, sum8(img)}, 32'h65);
    load(4'h0, img);
    send(8'h65);
    chk("done_fresh",   {31'd0, loadDone}, 32'd1);
    chk("hold_fresh",   {31'd0, cpuHold},  32'd0);
    chk("writes_fresh", expq.size(),       32'd0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/rom_loader.md
ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 SYNC_BYTE, 8'hA5, start-of-image marker.
REQ-002 clk  in  1  single system clock; all state changes on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 inData  in  8  incoming image byte.
REQ-005 inValid  in  1  inData valid this cycle.
REQ-006 inReady  out  1  loader accepts inData this cycle; a byte transfers when inValid && inReady.
REQ-007 romWe  out  1  one-cycle write strobe to program ROM store.
REQ-008 romWaddr  out  12  ROM byte address for romWe.
REQ-009 romWdata  out  8  ROM byte (OPR in [7:4], OPA in [3:0]) for romWe.
REQ-010 cpuHold  out  1  high holds the CPU core in reset; low releases it.
REQ-011 loadDone  out  1  image loaded and checksum matched.
REQ-012 loadErr  out  1  checksum mismatch on the last image.

Function
REQ-013 States: IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERR; exactly one active.
REQ-014 IDLE: accepted byte == SYNC_BYTE -> LEN_HI; any other byte is discarded and the state is unchanged.
REQ-015 LEN_HI: accept byte, length[11:8] <= byte[3:0] (byte[7:4] ignored) -> LEN_LO.
REQ-016 LEN_LO: accept byte, length[7:0] <= byte -> DATA; load address counter <= 0; checksum <= 0.
REQ-017 length == 0 encodes 4096 bytes; remaining-count is 13 bits wide.
REQ-018 DATA: each accepted byte is registered; next cycle romWe=1, romWaddr=counter, romWdata=byte; then counter +1, checksum +byte mod 256.
REQ-019 inReady=0 in the cycle romWe=1; throughput is at most one data byte per 2 cycles.
REQ-020 After the write of the last counted byte -> CSUM; the counter wraps 4095->0 only when length is 4096, and no write follows the wrap.
REQ-021 CSUM: accepted byte == checksum -> DONE, otherwise -> ERR.
REQ-022 DONE: loadDone=1, cpuHold=0; ERR: loadErr=1, cpuHold=1.
REQ-023 In DONE or ERR, accepted SYNC_BYTE -> LEN_HI; on that same edge cpuHold=1, loadDone=0, loadErr=0. Non-sync bytes are discarded.
REQ-024 inReady=1 in every state except the romWe cycle of REQ-019.
REQ-025 romWe never asserts outside DATA; romWaddr and romWdata hold their last values when romWe=0.
REQ-026 cpuHold is registered and glitch-free; it falls only on the edge entering DONE.
REQ-027 Back-to-back inValid with no gaps is handled without loss, respecting inReady.

Reset
REQ-028 When rst=1 on a clock edge, the state becomes IDLE.
REQ-029 The same reset edge sets inReady=1, romWe=0, romWaddr=0, romWdata=0, cpuHold=1, loadDone=0, loadErr=0, counters and checksum = 0.
REQ-030 Reset mid-load (any state) aborts the load; there is no partial write of a pending byte, and the next image must start with SYNC_BYTE.

Verification
REQ-031 rst, then A5,00,03,12,34,56,9C -> writes (0,12),(1,34),(2,56); loadDone=1; cpuHold falls 1 cycle after the 9C byte is accepted.
REQ-032 Same image with checksum 9D -> loadErr=1, cpuHold stays 1, loadDone=0.
REQ-033 Noise 00,FF before A5, then A5,00,01,7E,7E -> single write (0,7E), loadDone=1.
REQ-034 A5,00,00 then 4096 bytes of 01, then checksum 00 -> addresses 0..4095 written once each, no write to 0 after wrap, loadDone=1.
REQ-035 inValid held high continuously -> inReady toggles 1/0 in DATA, every byte written exactly once.
REQ-036 rst asserted after 2 of 3 data bytes -> cpuHold=1, no further romWe; a fresh full image then loads correctly.
